// File: rtl/audio_path_ctrl_if.sv
// audio_path_ctrl_if -- sample/codec bus bundle for audio_path_ctrl.
//   dry_in, wet_in : CH*W packed samples, channel c at [c*W +: W]
//   filt_done      : filter result valid pulse
//   codec_ready    : codec bus update enable
//   sample_trig    : filter start strobe
//   bus_out        : samples to codec L/R bus
//   mix_active     : crossfade in progress
//   overrun        : sticky filter overrun flag
//   clip           : sticky wet full-scale flag (only with AUDIO_PATH_CLIP_EN)
// master = sample source / filter / codec side, slave = audio_path_ctrl.
interface audio_path_ctrl_if #(
    parameter int W  = 24,
    parameter int CH = 2
);
    logic [CH*W-1:0] dry_in;
    logic [CH*W-1:0] wet_in;
    logic            filt_done;
    logic            codec_ready;
    logic            sample_trig;
    logic [CH*W-1:0] bus_out;
    logic            mix_active;
    logic            overrun;
`ifdef AUDIO_PATH_CLIP_EN
    logic            clip;
`endif

    modport master (
`ifdef AUDIO_PATH_CLIP_EN
        input  clip,
`endif
        output dry_in, wet_in, filt_done, codec_ready,
        input  sample_trig, bus_out, mix_active, overrun
    );

    modport slave (
`ifdef AUDIO_PATH_CLIP_EN
        output clip,
`endif
        input  dry_in, wet_in, filt_done, codec_ready,
        output sample_trig, bus_out, mix_active, overrun
    );
endinterface

// File: rtl/audio_path_ctrl.sv
// audio_path_ctrl -- sample strobe divider, filter handshake with overrun
// detection, debounced dry/wet crossfade and codec bus register.
//   clk, reset_n : clock, asynchronous active-low reset
//   sw           : asynchronous bypass select (1 = wet)
//   bus          : audio_path_ctrl_if.slave (samples, handshake, status)
// Optional build macro AUDIO_PATH_CLIP_EN adds the sticky bus.clip flag.

// One channel of the crossfade: m = (wet*g + dry*(G-g)) >>> RAMP_LOG2, registered.
module audio_path_lane #(
    parameter int W         = 24,
    parameter int RAMP_LOG2 = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic signed [W-1:0]  dry,
    input  logic signed [W-1:0]  wet,
    input  logic [RAMP_LOG2:0]   g,
    output logic [W-1:0]         mix_q
);
    localparam int GW = RAMP_LOG2 + 1;
    localparam int AW = W + RAMP_LOG2 + 1;
    localparam logic [GW-1:0] GV = GW'(1 << RAMP_LOG2);

    logic signed [AW-1:0] wet_x, dry_x, g_x, gi_x, acc;
    logic [W-1:0]         mix_d;
    logic                 lane_unused;

    always_comb begin
        wet_x = signed'({{(RAMP_LOG2+1){wet[W-1]}}, wet});
        dry_x = signed'({{(RAMP_LOG2+1){dry[W-1]}}, dry});
        g_x   = signed'({{(AW-GW){1'b0}}, g});
        gi_x  = signed'({{(AW-GW){1'b0}}, GV - g});
        acc   = wet_x * g_x + dry_x * gi_x;
        // Taking bits [RAMP_LOG2 +: W] is the arithmetic shift truncated to W.
        mix_d = acc[RAMP_LOG2 +: W];
    end

    // Sign bit and fraction bits are intentionally discarded.
    assign lane_unused = ^{acc[AW-1], acc[RAMP_LOG2-1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) mix_q <= '0;
        else          mix_q <= mix_d;
    end
endmodule

module audio_path_ctrl #(
    parameter int W         = 24,
    parameter int CH        = 2,
    parameter int DIV       = 5000,
    parameter int RAMP_LOG2 = 6,
    parameter int DEB_LOG2  = 16
) (
    input logic              clk,
    input logic              reset_n,
    input logic              sw,
    audio_path_ctrl_if.slave bus
);
    localparam int CW = $clog2(DIV);
    localparam int GW = RAMP_LOG2 + 1;
    localparam logic [GW-1:0] GV = GW'(1 << RAMP_LOG2);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {S_DRY, S_UP, S_WET, S_DOWN} state_t;

    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      trig;
    logic                      busy_q, busy_d;
    logic                      overrun_q, overrun_d;
    logic [CH-1:0][W-1:0]      dry_q, dry_d, wet_q, wet_d, mix_q, wet_in_a;
    logic [CH*W-1:0]           bus_out_q, bus_out_d;
    logic                      sw_s1_q, sw_s2_q;
    logic [DEB_LOG2-1:0]       deb_cnt_q, deb_cnt_d;
    logic                      sel_db_q, sel_db_d;
    state_t                    state_q;
    logic [GW-1:0]             g_q;
    logic                      mix_active_q;

    assign trig     = (cnt_q == CNT_LAST);
    assign wet_in_a = bus.wet_in;

    always_comb begin
        cnt_d     = trig ? '0 : cnt_q + CW'(1);
        dry_d     = trig ? bus.dry_in : dry_q;
        // A result landing together with the next strobe is still accepted,
        // and busy re-arms for the new sample.
        busy_d    = trig ? 1'b1 : (bus.filt_done ? 1'b0 : busy_q);
        wet_d     = (bus.filt_done && busy_q) ? wet_in_a : wet_q;
        overrun_d = overrun_q | (trig & busy_q & ~bus.filt_done);
        bus_out_d = bus.codec_ready ? mix_q : bus_out_q;
        // Count consecutive cycles the synchronised switch disagrees with the
        // debounced value; agreeing again restarts the count.
        deb_cnt_d = '0;
        sel_db_d  = sel_db_q;
        if (sw_s2_q != sel_db_q) begin
            if (deb_cnt_q == '1) sel_db_d  = sw_s2_q;
            else                 deb_cnt_d = deb_cnt_q + DEB_LOG2'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            dry_q     <= '0;
            wet_q     <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            bus_out_q <= '0;
            sw_s1_q   <= 1'b0;
            sw_s2_q   <= 1'b0;
            deb_cnt_q <= '0;
            sel_db_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dry_q     <= dry_d;
            wet_q     <= wet_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            bus_out_q <= bus_out_d;
            sw_s1_q   <= sw;
            sw_s2_q   <= sw_s1_q;
            deb_cnt_q <= deb_cnt_d;
            sel_db_q  <= sel_db_d;
        end
    end

    // Crossfade FSM. Direction changes take effect at once and keep the
    // current g; g itself only moves on the sample strobe. Reaching the end
    // of a ramp on a strobe enters the steady state in the same step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_DRY;
            g_q          <= '0;
            mix_active_q <= 1'b0;
        end else begin
            case (state_q)
                S_DRY: begin
                    g_q <= '0;
                    if (sel_db_q) begin
                        state_q      <= S_UP;
                        mix_active_q <= 1'b1;
                    end
                end
                S_UP: begin
                    if (!sel_db_q) begin
                        state_q      <= S_DOWN;
                        mix_active_q <= 1'b1;
                    end else if (g_q == GV) begin
                        state_q      <= S_WET;
                        mix_active_q <= 1'b0;
                    end else if (trig) begin
                        g_q <= g_q + GW'(1);
                        if (g_q == GV - GW'(1)) begin
                            state_q      <= S_WET;
                            mix_active_q <= 1'b0;
                        end
                    end
                end
                S_WET: begin
                    g_q <= GV;
                    if (!sel_db_q) begin
                        state_q      <= S_DOWN;
                        mix_active_q <= 1'b1;
                    end
                end
                S_DOWN: begin
                    if (sel_db_q) begin
                        state_q      <= S_UP;
                        mix_active_q <= 1'b1;
                    end else if (g_q == '0) begin
                        state_q      <= S_DRY;
                        mix_active_q <= 1'b0;
                    end else if (trig) begin
                        g_q <= g_q - GW'(1);
                        if (g_q == GW'(1)) begin
                            state_q      <= S_DRY;
                            mix_active_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q      <= S_DRY;
                    g_q          <= '0;
                    mix_active_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        audio_path_lane #(.W(W), .RAMP_LOG2(RAMP_LOG2)) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .dry     (dry_q[c]),
            .wet     (wet_q[c]),
            .g       (g_q),
            .mix_q   (mix_q[c])
        );
    end

`ifdef AUDIO_PATH_CLIP_EN
    localparam logic [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};
    logic clip_q, clip_d;

    always_comb begin
        clip_d = clip_q;
        if (bus.filt_done && busy_q) begin
            for (int c = 0; c < CH; c++) begin
                if (wet_in_a[c] == S_MAX || wet_in_a[c] == S_MIN) clip_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) clip_q <= 1'b0;
        else          clip_q <= clip_d;
    end

    assign bus.clip = clip_q;
`endif

    assign bus.sample_trig = trig;
    assign bus.bus_out     = bus_out_q;
    assign bus.mix_active  = mix_active_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_audio_path_ctrl.sv
module tb_audio_path_ctrl;
    localparam int W = 24, CH = 2, DIV = 8, RL = 2, DL = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sw = 1'b0;
    int   n_chk = 0, n_pass = 0;
    int   done_dly = 3, done_cnt = 0;

    always #5 clk = ~clk;

    audio_path_ctrl_if #(.W(W), .CH(CH)) bus ();

    audio_path_ctrl #(.W(W), .CH(CH), .DIV(DIV), .RAMP_LOG2(RL), .DEB_LOG2(DL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sw      (sw),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [47:0] pk(input logic [23:0] c1, input logic [23:0] c0);
        return {c1, c0};
    endfunction

    task automatic next_trig();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.sample_trig && k < 2 * DIV);
        chk("trig_seen", bus.sample_trig, 1);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    // Filter model: answers done_dly cycles after each strobe (0 = never).
    initial begin
        bus.filt_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.filt_done = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) bus.filt_done = 1'b1;
            end
            if (bus.sample_trig) done_cnt = done_dly;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first, ntrig, badgap, last;
        bus.dry_in      = pk(24'hFFFF00, 24'h000100);
        bus.wet_in      = '0;
        bus.codec_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bus",  bus.bus_out, 0);
        chk("rst_trig", bus.sample_trig, 0);
        chk("rst_mix",  bus.mix_active, 0);
        chk("rst_ovr",  bus.overrun, 0);

        // 1: divider period and bus hold without codec_ready
        reset_n = 1'b1;
        first = -1; ntrig = 0; badgap = 0; last = -1;
        for (int k = 0; k < 40; k++) begin
            if (bus.sample_trig) begin
                ntrig++;
                if (first < 0) first = k;
                else if (k - last != DIV) badgap++;
                last = k;
            end
            @(negedge clk);
        end
        chk("trig_first", first, 7);
        chk("trig_count", ntrig, 5);
        chk("trig_gap", badgap, 0);
        chk("bus_hold", bus.bus_out, 0);

        // 2: dry pass-through
        bus.codec_ready = 1'b1;
        next_trig(); settle();
        chk("dry_pass", bus.bus_out, pk(24'hFFFF00, 24'h000100));
        chk("p2_ovr", bus.overrun, 0);
        chk("p2_mix", bus.mix_active, 0);
        bus.dry_in = pk(24'h800000, 24'h7FFFFF);
        next_trig(); settle();
        chk("dry_ext", bus.bus_out, pk(24'h800000, 24'h7FFFFF));

        // 4a: short glitch must not leave DRY
        sw = 1'b1; repeat (2) @(negedge clk); sw = 1'b0;
        next_trig(); settle();
        chk("glitch_mix", bus.mix_active, 0);
        chk("glitch_bus", bus.bus_out, pk(24'h800000, 24'h7FFFFF));

        // 3: ramp up to wet
        bus.dry_in = '0;
        bus.wet_in = pk(24'h000400, 24'h000400);
        next_trig(); next_trig();
        sw = 1'b1;
        settle();
        chk("up_g0", bus.bus_out, 0);
        for (int i = 1; i <= 4; i++) begin
            next_trig(); settle();
            chk("up_bus", bus.bus_out, pk(24'(i * 'h100), 24'(i * 'h100)));
            chk("up_mix", bus.mix_active, (i < 4) ? 1 : 0);
        end

        // ramp back down to dry
        next_trig();
        sw = 1'b0;
        settle();
        chk("wet_hold", bus.bus_out, pk(24'h000400, 24'h000400));
        for (int i = 3; i >= 0; i--) begin
            next_trig(); settle();
            chk("dn_bus", bus.bus_out, pk(24'(i * 'h100), 24'(i * 'h100)));
            chk("dn_mix", bus.mix_active, (i > 0) ? 1 : 0);
        end

        // 4b: signed blend and reversal at g=2
        bus.dry_in = pk(24'hFFFFFF, 24'h000100);
        bus.wet_in = pk(24'hFFFC00, 24'h000400);
        next_trig();
        sw = 1'b1;
        settle();
        chk("rev_g0", bus.bus_out, pk(24'hFFFFFF, 24'h000100));
        next_trig(); settle();
        chk("rev_g1", bus.bus_out, pk(24'hFFFEFF, 24'h0001C0));
        next_trig();
        sw = 1'b0;
        settle();
        chk("rev_g2", bus.bus_out, pk(24'hFFFDFF, 24'h000280));
        chk("rev_g2_mix", bus.mix_active, 1);
        next_trig(); settle();
        chk("rev_dn1", bus.bus_out, pk(24'hFFFEFF, 24'h0001C0));
        chk("rev_dn1_mix", bus.mix_active, 1);
        next_trig(); settle();
        chk("rev_dn0", bus.bus_out, pk(24'hFFFFFF, 24'h000100));
        chk("rev_dn0_mix", bus.mix_active, 0);

        // 5: coincident done is fine, a missing done is an overrun
        chk("pre_ovr", bus.overrun, 0);
        done_dly = 8;
        next_trig(); next_trig(); next_trig(); settle();
        chk("coinc_ovr", bus.overrun, 0);
        done_dly = 0;
        next_trig(); next_trig(); settle();
        chk("ovr_set", bus.overrun, 1);
        done_dly = 3;
        next_trig(); settle();
        chk("ovr_sticky", bus.overrun, 1);

        // 6: reset in the middle of a ramp
        next_trig();
        sw = 1'b1;
        next_trig(); next_trig(); settle();
        chk("p6_g2", bus.bus_out, pk(24'hFFFDFF, 24'h000280));
        reset_n = 1'b0;
        #1;
        chk("rst2_bus", bus.bus_out, 0);
        chk("rst2_mix", bus.mix_active, 0);
        chk("rst2_ovr", bus.overrun, 0);
        sw = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        next_trig(); settle();
        chk("post_rst_mix", bus.mix_active, 0);
        chk("post_rst_bus", bus.bus_out, pk(24'hFFFFFF, 24'h000100));
        chk("post_rst_ovr", bus.overrun, 0);

`ifdef AUDIO_PATH_CLIP_EN
        chk("clip_pre", bus.clip, 0);
        bus.wet_in = pk(24'h000000, 24'h7FFFFF);
        next_trig(); settle();
        chk("clip_set", bus.clip, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
